// File: rtl/aes256_key_sched_ctrl_pkg.sv
// Shared types and constants for the AES-256 key-schedule controller:
// FSM states, store geometry and the round-index to store-slot mapping.
package aes_ks_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int         NUM_RK     = 15;
  localparam logic [3:0] LAST_ROUND = 4'd15;
  localparam int         RK_W       = 128;
  localparam int         KEY_W      = 256;

  // Decrypt order stores round key i where cipher round 14-i will look for it.
  function automatic logic [3:0] rk_slot(input logic [3:0] idx, input logic inv);
    return inv ? (4'd14 - idx) : idx;
  endfunction

endpackage

// File: rtl/aes256_key_sched_ctrl_if.sv
// Key-load handshake and round-key read port between the requester and the
// key-schedule controller.
interface aes256_key_sched_ctrl_if;
  import aes_ks_pkg::*;

  logic             key_valid;
  logic [KEY_W-1:0] key_in;
  logic             inv_mode;
  logic             key_ready;
  logic [3:0]       rk_addr;
  logic [RK_W-1:0]  rk_data;
  logic             sched_done;
  logic             busy;

  modport master (
    output key_valid, key_in, inv_mode, rk_addr,
    input  key_ready, rk_data, sched_done, busy
  );

  modport slave (
    input  key_valid, key_in, inv_mode, rk_addr,
    output key_ready, rk_data, sched_done, busy
  );
endinterface

// File: rtl/aes256_key_sched_ctrl_rk_store.sv
// Round-key register file: one write port, one registered read port,
// whole array cleared by the asynchronous reset.
module rk_store #(
  parameter int NUM_RK = 15,
  parameter int RK_W   = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [3:0]      waddr_i,
  input  logic [RK_W-1:0] wdata_i,
  input  logic [3:0]      raddr_i,
  output logic [RK_W-1:0] rdata_o
);

  logic [RK_W-1:0] mem_q [NUM_RK];
  logic [RK_W-1:0] rdata_q;

  // NOTE: the array sits on the async reset so an aborted schedule can never
  // leave keys readable; this forces flops rather than an SRAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RK; i++) mem_q[i] <= '0;
    end else if (we_i && (int'(waddr_i) < NUM_RK)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-slot read during a write returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (int'(raddr_i) < NUM_RK) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Sequences the AES-256 key-expansion datapath through rounds 0..15 and
// captures the 15 round keys into rk_store in encrypt or decrypt order.
module aes256_key_sched_ctrl #(
  parameter int NUM_RK    = 15,
  parameter int KEY_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes256_key_sched_ctrl_if.slave bus,
  output logic [KEY_WIDTH-1:0]   ks_key_o,
  output logic [3:0]             ks_round_o,
  output logic                   ks_inv_en_o,
  input  logic [KEY_WIDTH/2-1:0] ks_round_key_i
);
  import aes_ks_pkg::*;

  state_e                 state_q, state_d;
  logic [3:0]             rc_q, rc_d;
  logic [KEY_WIDTH-1:0]   key_q;
  logic                   inv_q;
  logic                   key_hs;
  logic                   key_ready;
  logic                   busy;
  logic                   sched_done;
  logic                   rk_we;
  logic [3:0]             rk_idx;
  logic [3:0]             rk_waddr;
  logic [KEY_WIDTH/2-1:0] rk_rdata;

  assign key_hs = bus.key_valid && key_ready;

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      inv_q <= 1'b0;
    end else if (key_hs) begin
      key_q <= bus.key_in;
      inv_q <= bus.inv_mode;
    end
  end

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (key_hs) begin
          state_d = LOAD;
          rc_d    = 4'd0;
        end
      end
      LOAD: begin
        rc_d = rc_q + 4'd1;
        if (rc_q == 4'd1) state_d = EXPAND;
      end
      EXPAND: begin
        // rc is never advanced past the last round.
        if (rc_q == LAST_ROUND) state_d = DONE;
        else                    rc_d    = rc_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_ready  = (state_q == IDLE) || (state_q == DONE);
    busy       = (state_q == LOAD) || (state_q == EXPAND);
    sched_done = (state_q == DONE);
    ks_round_o = busy ? rc_q : 4'd0;
    // Round 1 is the datapath's second reload cycle and carries no key.
    rk_we      = busy && (rc_q != 4'd1);
    rk_idx     = (rc_q == 4'd0) ? 4'd0 : (rc_q - 4'd1);
    rk_waddr   = rk_slot(rk_idx, inv_q);
  end

  rk_store #(
    .NUM_RK (NUM_RK),
    .RK_W   (KEY_WIDTH/2)
  ) u_rk_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (rk_we),
    .waddr_i (rk_waddr),
    .wdata_i (ks_round_key_i),
    .raddr_i (bus.rk_addr),
    .rdata_o (rk_rdata)
  );

  assign ks_key_o       = key_q;
  assign ks_inv_en_o    = inv_q;
  assign bus.key_ready  = key_ready;
  assign bus.busy       = busy;
  assign bus.sched_done = sched_done;
  assign bus.rk_data    = rk_rdata;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Self-checking bench: behavioural AES-256 expansion drives a datapath model;
// stored round keys are checked against the FIPS-197 key schedule.
module tb_aes256_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] ks_key;
  logic [3:0]   ks_round;
  logic         ks_inv_en;
  logic [127:0] dp_rk;
  int           n_checks = 0;
  int           n_fail   = 0;

  aes256_key_sched_ctrl_if bus();

  aes256_key_sched_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .ks_key_o       (ks_key),
    .ks_round_o     (ks_round),
    .ks_inv_en_o    (ks_inv_en),
    .ks_round_key_i (dp_rk)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- AES-256 reference arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] s = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, s);   // a^254 = multiplicative inverse
      s = gf_mul(s, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [59:0][31:0] expand(input logic [255:0] key);
    logic [59:0][31:0] w;
    logic [31:0]       t;
    logic [7:0]        rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    return w;
  endfunction

  function automatic logic [127:0] rk_from_w(input logic [59:0][31:0] w, input int idx);
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  // Key used by cipher round k: decryption walks the schedule backwards.
  function automatic logic [127:0] exp_rk(input logic [255:0] key, input bit inv, input int k);
    return rk_from_w(expand(key), inv ? 14 - k : k);
  endfunction

  // ---------------- datapath model ----------------
  logic [59:0][31:0] dp_w;
  always_comb dp_w = expand(ks_key);
  always_comb begin
    if (ks_round == 4'd0)      dp_rk = ks_key[255:128];
    else if (ks_round == 4'd1) dp_rk = {4{32'hdeadbeef}};
    else                       dp_rk = rk_from_w(dp_w, int'(ks_round) - 1);
  end

  // ---------------- checking and stimulus ----------------
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic start_key(input logic [255:0] key, input bit inv);
    int waited = 0;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_in    = key;
    bus.inv_mode  = inv;
    while (!bus.key_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("ready_timeout", 256'(waited < 40), 256'(1));
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_in    = rand_key();
    bus.inv_mode  = ~inv;
    check("done_clear", 256'(bus.sched_done), 256'(0));
    check("ks_key", ks_key, key);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_ready"}, 256'(bus.key_ready), 256'(1));
    check({tag, "_busy"},  256'(bus.busy), 256'(0));
    check({tag, "_done"},  256'(bus.sched_done), 256'(0));
    check({tag, "_round"}, 256'(ks_round), 256'(0));
    check({tag, "_inv"},   256'(ks_inv_en), 256'(0));
    check({tag, "_key"},   ks_key, 256'(0));
    check({tag, "_rd"},    256'(bus.rk_data), 256'(0));
  endtask

  // Follows one schedule; optional key_valid pulse or reset at a busy cycle.
  task automatic run_sched(input bit inv, input int inject_at, input int rst_at);
    int cyc = 0;
    bit finished = 1'b0;
    while (!finished && cyc < 40) begin
      @(negedge clk);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        expect_reset_outputs("midrst");
        #1 rst_n = 1'b1;
        return;
      end
      if (cyc == inject_at + 1) bus.key_valid = 1'b0;
      if (bus.busy) begin
        check("round", 256'(ks_round), 256'(cyc));
        check("inv_en", 256'(ks_inv_en), 256'(inv));
        if (cyc == inject_at) begin
          check("ready_busy", 256'(bus.key_ready), 256'(0));
          bus.key_valid = 1'b1;
          bus.key_in    = rand_key();
        end
        cyc++;
      end else begin
        finished = 1'b1;
      end
    end
    bus.key_valid = 1'b0;
    check("busy_cycles", 256'(cyc), 256'(16));
    check("sched_done", 256'(bus.sched_done), 256'(1));
    check("ready_done", 256'(bus.key_ready), 256'(1));
    check("round_idle", 256'(ks_round), 256'(0));
  endtask

  task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
    @(negedge clk);
    bus.rk_addr = a;
    @(posedge clk);
    #1 d = bus.rk_data;
  endtask

  task automatic read_all(input logic [255:0] key, input bit inv);
    logic [127:0] d;
    for (int k = 0; k < 15; k++) begin
      read_rk(4'(k), d);
      check($sformatf("rk%0d", k), 256'(d), 256'(exp_rk(key, inv, k)));
    end
  endtask

  initial begin
    logic [255:0] fips_key, k1, k2;
    logic [127:0] d;
    bit           inv;

    for (int i = 0; i < 32; i++) fips_key[255-8*i -: 8] = 8'(i);
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.inv_mode  = 1'b0;
    bus.rk_addr   = 4'd0;

    repeat (2) @(negedge clk);
    expect_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    expect_reset_outputs("post_reset");

    // FIPS-197 key, encrypt order
    start_key(fips_key, 1'b0);
    run_sched(1'b0, -1, -1);
    read_rk(4'd0, d);
    check("fips_rk0", 256'(d), 256'(128'h000102030405060708090a0b0c0d0e0f));
    read_rk(4'd1, d);
    check("fips_rk1", 256'(d), 256'(128'h101112131415161718191a1b1c1d1e1f));
    read_rk(4'd14, d);
    check("fips_rk14_w56", 256'(d[127:96]), 256'(32'h24fc79cc));
    read_all(fips_key, 1'b0);

    // Address beyond the store reads as zero
    read_rk(4'd15, d);
    check("addr15", 256'(d), 256'(0));

    // FIPS-197 key, decrypt order (back-to-back from DONE)
    start_key(fips_key, 1'b1);
    run_sched(1'b1, -1, -1);
    read_rk(4'd0, d);
    check("inv_rk0", 256'(d), 256'(exp_rk(fips_key, 1'b0, 14)));
    check("inv_rk0_w56", 256'(d[127:96]), 256'(32'h24fc79cc));
    read_rk(4'd14, d);
    check("inv_rk14", 256'(d), 256'(128'h000102030405060708090a0b0c0d0e0f));
    check("inv_en_done", 256'(ks_inv_en), 256'(1));

    // key_valid pulsed mid-expansion is ignored
    k1 = rand_key();
    start_key(k1, 1'b0);
    run_sched(1'b0, 5, -1);
    check("ks_key_kept", ks_key, k1);
    read_all(k1, 1'b0);

    // Reset at cycle 8 discards the partial schedule
    k2 = rand_key();
    start_key(k2, 1'b1);
    run_sched(1'b1, -1, 8);
    read_rk(4'd3, d);
    check("store_cleared", 256'(d), 256'(0));
    k2 = rand_key();
    start_key(k2, 1'b0);
    run_sched(1'b0, -1, -1);
    read_all(k2, 1'b0);

    // Randomized back-to-back schedules
    for (int n = 0; n < 6; n++) begin
      k1  = rand_key();
      inv = 1'($urandom_range(0, 1));
      start_key(k1, inv);
      run_sched(inv, -1, -1);
      read_all(k1, inv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
